// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// FSM state encoding, header interpretation and memory sizing helper.
package imem_loader_pkg;

    // Loader FSM states, 3-bit encoding IDLE=0 .. ERROR=5.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHK   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    // A header byte of zero stands for a full memory image (MAX_WORDS words).
    localparam bit HDR_ZERO_MEANS_MAX = 1'b1;

    // Number of 32-bit words addressable with a byte address of addr_w bits.
    function automatic int max_words(input int addr_w);
        return 2 ** (addr_w - 2);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: collects four bytes big-endian (first byte -> bits 31:24)
// and presents the finished word for exactly one cycle on word_valid.
// word stays stable between completions so it can drive write data directly.
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic        word_done,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_reg;
    logic [23:0] shift_reg;
    logic        word_valid_reg;
    logic [31:0] word_reg;

    // Combinational flag: the byte being accepted now completes a word.
    assign word_done  = accept && (cnt_reg == 2'd3);
    assign word_valid = word_valid_reg;
    assign word       = word_reg;

    // Byte counter, shift register and registered word output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg        <= 2'd0;
            shift_reg      <= 24'd0;
            word_valid_reg <= 1'b0;
            word_reg       <= 32'd0;
        end else begin
            word_valid_reg <= word_done;
            if (clear) begin
                cnt_reg   <= 2'd0;
                shift_reg <= 24'd0;
            end else if (accept) begin
                cnt_reg   <= cnt_reg + 2'd1;
                shift_reg <= {shift_reg[15:0], data};
                if (cnt_reg == 2'd3) begin
                    word_reg <= {shift_reg, data};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (header N, N big-endian words,
// optional check byte) and writes the words to instruction memory starting
// at address 0, holding the CPU in reset until a good frame has landed.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the trailing check
// byte and the CHK state; without it DATA goes straight to DONE.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int MAX_WORDS = max_words(ADDR_W);
    localparam int IDX_W     = ADDR_W - 2;
    localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(MAX_WORDS - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [IDX_W-1:0]  word_index_reg;
    logic [IDX_W-1:0]  last_index_reg;
    logic [ADDR_W-1:0] addr_reg;

    logic              xfer;
    logic              hdr_accept;
    logic              data_accept;
    logic              hdr_bad;
    logic [IDX_W-1:0]  hdr_last;
    logic              word_done;
    logic              last_word;

    assign busy     = (state_reg == ST_HDR) || (state_reg == ST_DATA) || (state_reg == ST_CHK);
    assign in_ready = busy;
    assign done     = (state_reg == ST_DONE);
    assign error    = (state_reg == ST_ERROR);
    assign cpu_hold = (state_reg != ST_DONE);

    assign xfer        = in_valid && in_ready;
    assign hdr_accept  = xfer && (state_reg == ST_HDR);
    assign data_accept = xfer && (state_reg == ST_DATA);

    // Header decode: count too large, or zero when zero is not a shorthand.
    assign hdr_bad  = (32'(in_data) > MAX_WORDS) ||
                      (!HDR_ZERO_MEANS_MAX && (in_data == 8'd0));
    assign hdr_last = (in_data == 8'd0) ? LAST_MAX : IDX_W'(in_data - 8'd1);

    assign last_word = word_done && (word_index_reg == last_index_reg);

    word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (state_reg == ST_HDR),
        .accept     (data_accept),
        .data       (in_data),
        .word_done  (word_done),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    assign imem_addr = addr_reg;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum_reg;
    logic [7:0] chk_total;

    assign chk_total = sum_reg + in_data;

    // Running 8-bit sum of data bytes, restarted by each header.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_reg <= 8'd0;
        end else if (hdr_accept) begin
            sum_reg <= 8'd0;
        end else if (data_accept) begin
            sum_reg <= sum_reg + in_data;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; load_req only matters in IDLE, DONE and ERROR.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (load_req) state_next = ST_HDR;
            end
            ST_HDR: begin
                if (xfer) state_next = hdr_bad ? ST_ERROR : ST_DATA;
            end
            ST_DATA: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = ST_CHK;
`else
                    state_next = ST_DONE;
`endif
                end
            end
            ST_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (xfer) state_next = (chk_total == 8'd0) ? ST_DONE : ST_ERROR;
`else
                state_next = ST_IDLE;
`endif
            end
            ST_DONE, ST_ERROR: begin
                if (load_req) state_next = ST_HDR;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Word index / frame length and the registered write address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_index_reg <= '0;
            last_index_reg <= '0;
            addr_reg       <= '0;
        end else begin
            if (hdr_accept) begin
                word_index_reg <= '0;
                last_index_reg <= hdr_last;
            end else if (word_done) begin
                addr_reg       <= {word_index_reg, 2'b00};
                word_index_reg <= word_index_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frames plus hand-written
// sequences for exact write timing, full-size header, reset abort and
// load_req while busy. Define IMEM_LOADER_CHECKSUM_EN to test that build.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        load_req;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int wide_err = 0;
    logic we_prev = 1'b0;
    logic [7:0]  addr_q[$];
    logic [31:0] data_q[$];

    typedef struct {
        logic [7:0]  hdr;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        int          gap;
        logic [7:0]  chk;
    } frame_t;

    frame_t frames[5];

    imem_loader #(.ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .load_req   (load_req),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: log every write and flag strobes wider than one cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            addr_q.push_back(imem_addr);
            data_q.push_back(imem_wdata);
            if (we_prev) wide_err <= wide_err + 1;
        end
        we_prev <= imem_we;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        in_data  = 8'hFF;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'hFF;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    function automatic logic [31:0] fword(input frame_t f, input int i);
        return (i == 0) ? f.w0 : (i == 1) ? f.w1 : f.w2;
    endfunction

    task automatic run_frame(input frame_t f, input int idx);
        logic [7:0]  sum;
        logic [31:0] w;
        logic [7:0]  b;
        logic        ok;
        int          exp_writes;
        addr_q.delete();
        data_q.delete();
        pulse_load();
        check("busy_after_req", {31'd0, busy}, 32'd1);
        send(f.hdr, $urandom_range(0, f.gap));
        sum = 8'd0;
        for (int i = 0; i < f.nw; i++) begin
            w = fword(f, i);
            for (int k = 0; k < 4; k++) begin
                b = w[31 - 8*k -: 8];
                sum = sum + b;
                send(b, $urandom_range(0, f.gap));
            end
        end
        ok = (f.hdr <= 8'd64);
        exp_writes = ok ? f.nw : 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (ok) begin
            send(f.chk, $urandom_range(0, f.gap));
            ok = ((sum + f.chk) == 8'd0);
        end
`endif
        repeat (2) @(posedge clk);
        #1;
        check("write_count", 32'(addr_q.size()), 32'(exp_writes));
        for (int i = 0; i < exp_writes && i < addr_q.size(); i++) begin
            check("write_addr", {24'd0, addr_q[i]}, 32'(i * 4));
            check("write_data", data_q[i], fword(f, i));
        end
        check("done", {31'd0, done}, {31'd0, ok});
        check("error", {31'd0, error}, {31'd0, !ok});
        check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !ok});
        check("busy_end", {31'd0, busy}, 32'd0);
        $display("frame %0d: hdr=0x%02h writes=%0d done=%0b error=%0b", idx, f.hdr, addr_q.size(), done, error);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
        check({tag, "_imem_addr"}, {24'd0, imem_addr}, 32'd0);
        check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [31:0] w;
        logic [31:0] ew;

        // Frame table: hdr, words, payload, max gap, check byte.
        frames[0] = '{8'h02, 2, 32'h20080005, 32'h8C090004, 32'h0, 0, 8'h3A};
        frames[1] = '{8'h02, 2, 32'h20080005, 32'h8C090004, 32'h0, 0, 8'h3B};
        frames[2] = '{8'h03, 3, 32'h12345678, 32'hA5A5005A, 32'hFFFF0001, 5, 8'hA3};
        frames[3] = '{8'h41, 0, 32'h0, 32'h0, 32'h0, 2, 8'h00};
        frames[4] = '{8'h01, 1, 32'hDEADBEEF, 32'h0, 32'h0, 3, 8'hC8};

        rst_n    = 1'b0;
        load_req = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Exact write timing for the reference two-word frame.
        addr_q.delete();
        data_q.delete();
        pulse_load();
        send(8'h02, 0);
        send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h05, 0);
        check("w0_strobe", {31'd0, imem_we}, 32'd1);
        check("w0_addr", {24'd0, imem_addr}, 32'h00);
        check("w0_data", imem_wdata, 32'h20080005);
        send(8'h8C, 0); send(8'h09, 0); send(8'h00, 0); send(8'h04, 0);
        check("w1_strobe", {31'd0, imem_we}, 32'd1);
        check("w1_addr", {24'd0, imem_addr}, 32'h04);
        check("w1_data", imem_wdata, 32'h8C090004);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("w1_busy_chk", {31'd0, busy}, 32'd1);
        check("w1_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        send(8'h3A, 0);
`else
        check("w1_done", {31'd0, done}, 32'd1);
        check("w1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("w1_busy", {31'd0, busy}, 32'd0);
`endif
        @(posedge clk);
        #1;
        check("we_single_cycle", {31'd0, imem_we}, 32'd0);
        check("ref_done", {31'd0, done}, 32'd1);
        $display("reference frame: done=%0b cpu_hold=%0b", done, cpu_hold);

        // load_req in DONE: busy and cpu_hold the next cycle.
        pulse_load();
        check("done_req_busy", {31'd0, busy}, 32'd1);
        check("done_req_hold", {31'd0, cpu_hold}, 32'd1);

        // Table-driven frames (first one issues load_req while already busy).
        for (int i = 0; i < 5; i++) begin
            run_frame(frames[i], i);
        end

        // Header 0: full 64-word image.
        addr_q.delete();
        data_q.delete();
        pulse_load();
        send(8'h00, 0);
        sum = 8'd0;
        for (int j = 0; j < 256; j++) begin
            b = 8'(j) ^ 8'h3C;
            sum = sum + b;
            send(b, 0);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'd0 - sum, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("full_count", 32'(addr_q.size()), 32'd64);
        for (int i = 0; i < 64 && i < addr_q.size(); i++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(4 * i + k) ^ 8'h3C;
                ew[31 - 8*k -: 8] = b;
            end
            check("full_addr", {24'd0, addr_q[i]}, 32'(i * 4));
            check("full_data", data_q[i], ew);
        end
        if (addr_q.size() > 0) check("full_last_addr", {24'd0, addr_q[addr_q.size() - 1]}, 32'hFC);
        check("full_done", {31'd0, done}, 32'd1);
        $display("full frame: writes=%0d done=%0b", addr_q.size(), done);

        // Reset after six data bytes aborts the load.
        addr_q.delete();
        data_q.delete();
        pulse_load();
        send(8'h02, 0);
        w = 32'h20080005;
        for (int k = 0; k < 4; k++) send(w[31 - 8*k -: 8], 0);
        send(8'h8C, 0);
        send(8'h09, 0);
        check("abort_writes", 32'(addr_q.size()), 32'd1);
        #2;
        rst_n = 1'b0;
        #2;
        check_reset_values("abort");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset abort: writes before reset=%0d", addr_q.size());
        run_frame(frames[0], 5);

        // load_req during DATA must not disturb the byte stream.
        addr_q.delete();
        data_q.delete();
        pulse_load();
        send(8'h02, 0);
        send(8'h20, 0);
        send(8'h08, 0);
        load_req = 1'b1;
        send(8'h00, 0);
        send(8'h05, 1);
        load_req = 1'b0;
        send(8'h8C, 0); send(8'h09, 0); send(8'h00, 0); send(8'h04, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h3A, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("busyreq_count", 32'(addr_q.size()), 32'd2);
        if (addr_q.size() == 2) begin
            check("busyreq_addr0", {24'd0, addr_q[0]}, 32'h00);
            check("busyreq_data0", data_q[0], 32'h20080005);
            check("busyreq_addr1", {24'd0, addr_q[1]}, 32'h04);
            check("busyreq_data1", data_q[1], 32'h8C090004);
        end
        check("busyreq_done", {31'd0, done}, 32'd1);
        $display("load_req during DATA: writes=%0d done=%0b", addr_q.size(), done);

        check("we_width_violations", 32'(wide_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
